// File: rtl/seq_hit_counter_pkg.sv
// Shared definitions for the freqcnt hit counter: state encoding and default sizes.
package seq_hit_counter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GATE = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_GATE = GATE,
    ST_HOLD = HOLD
  } state_e;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_CNT_W       = 16;

  // Timer must hold GATE_CYCLES-1; a one-cycle gate still needs one bit.
  function automatic int timer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_hit_counter_gate_timer.sv
// Gate window down-counter: load GATE_CYCLES-1, decrement on request, flag zero.
module gate_timer
  import seq_hit_counter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic last
);

  localparam int TW = timer_w(GATE_CYCLES);

  logic [TW-1:0] tmr_q, tmr_d;

  always_comb begin
    tmr_d = tmr_q;
    if (load)
      tmr_d = TW'(GATE_CYCLES - 1);
    else if (dec && (tmr_q != '0))
      tmr_d = tmr_q - TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end

  assign last = (tmr_q == '0);

endmodule

// File: rtl/seq_hit_counter.sv
// Gated match counter: counts hit pulses over a fixed window, offers result via valid/ready.
// state | meaning: IDLE wait for start | GATE counting hits | HOLD result offered, hits lost
module seq_hit_counter
  import seq_hit_counter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             start,
  input  logic             cont,
  input  logic             count_ready,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             overflow
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   acc_q, acc_d, acc_nxt;
  logic               ovf_q, ovf_d, ovf_nxt;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               tmr_load, tmr_dec, tmr_last;

  gate_timer #(.GATE_CYCLES(GATE_CYCLES)) u_gate_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .last (tmr_last)
  );

  // Saturating increment; the flag stays set for the rest of the window.
  always_comb begin
    acc_nxt = acc_q;
    ovf_nxt = ovf_q;
    if (hit) begin
      if (acc_q == {CNT_W{1'b1}}) ovf_nxt = 1'b1;
      else                        acc_nxt = acc_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_GATE;
          acc_d    = '0;
          ovf_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_GATE: begin
        acc_d = acc_nxt;
        ovf_d = ovf_nxt;
        if (tmr_last) begin
          count_d    = acc_nxt;
          overflow_d = ovf_nxt;
          valid_d    = 1'b1;
          state_d    = ST_HOLD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (valid_q && count_ready) begin
          valid_d = 1'b0;
          if (cont) begin
            state_d  = ST_GATE;
            acc_d    = '0;
            ovf_d    = 1'b0;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign count       = count_q;
  assign count_valid = valid_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_hit_counter.sv
// Directed bench: main instance (8-cycle gate, 4-bit), a 2-bit saturating copy and a 1-cycle gate copy.
module tb_seq_hit_counter;

  logic clk = 1'b0;
  logic rst, hit, start, cont, count_ready;

  logic       busy_a, valid_a, ovf_a;
  logic [3:0] count_a;
  logic       busy_s, valid_s, ovf_s;
  logic [1:0] count_s;
  logic       busy_1, valid_1, ovf_1;
  logic [3:0] count_1;

  int n_assert = 0;
  int n_fail   = 0;
  int n;

  always #5 clk = ~clk;

  seq_hit_counter #(.GATE_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .hit(hit), .start(start), .cont(cont),
    .count_ready(count_ready), .busy(busy_a), .count(count_a),
    .count_valid(valid_a), .overflow(ovf_a)
  );

  seq_hit_counter #(.GATE_CYCLES(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hit(hit), .start(start), .cont(cont),
    .count_ready(count_ready), .busy(busy_s), .count(count_s),
    .count_valid(valid_s), .overflow(ovf_s)
  );

  seq_hit_counter #(.GATE_CYCLES(1), .CNT_W(4)) dut_g1 (
    .clk(clk), .rst(rst), .hit(hit), .start(start), .cont(cont),
    .count_ready(count_ready), .busy(busy_1), .count(count_1),
    .count_valid(valid_1), .overflow(ovf_1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps with current inputs until the main instance shows valid; returns edges taken.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!valid_a && cnt < 40);
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; start = 1'b0; cont = 1'b0; count_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy",  busy_a,  0);
    chk("rst_count", count_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_ovf",   ovf_a,   0);

    // Basic window: hits on edges 0,1,3,8,9 with start at edge 0
    start = 1'b1; hit = 1'b1; step();          // edge 0
    start = 1'b0;
    chk("basic_busy0", busy_a, 1);
    chk("basic_valid0", valid_a, 0);
    hit = 1'b1; step();                          // edge 1
    chk("g1_valid", valid_1, 1);
    chk("g1_count", count_1, 1);
    hit = 1'b0; step();                          // edge 2
    hit = 1'b1; step();                          // edge 3
    hit = 1'b0;
    for (int i = 4; i <= 7; i++) step();
    chk("basic_valid7", valid_a, 0);
    hit = 1'b1; step();                          // edge 8
    chk("basic_valid8", valid_a, 1);
    chk("basic_count", count_a, 3);
    chk("basic_ovf", ovf_a, 0);
    step();                                      // edge 9, in HOLD
    chk("basic_count9", count_a, 3);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      hit = i[0];
      step();
      chk("bp_valid", valid_a, 1);
      chk("bp_count", count_a, 3);
    end
    hit = 1'b0; count_ready = 1'b1; step();
    count_ready = 1'b0;
    chk("bp_valid_drop", valid_a, 0);
    chk("bp_idle", busy_a, 0);
    step();
    chk("bp_count_kept", count_a, 3);

    // Saturation: 8 hits into a 2-bit accumulator
    start = 1'b1; hit = 1'b1; step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("sat_valid", valid_s, 1);
    chk("sat_count", count_s, 3);
    chk("sat_ovf", ovf_s, 1);
    chk("sat_main_count", count_a, 8);
    chk("sat_main_ovf", ovf_a, 0);
    hit = 1'b0; count_ready = 1'b1; step();
    count_ready = 1'b0;
    start = 1'b1; step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      hit = (i == 3);
      step();
    end
    hit = 1'b0;
    chk("sat2_valid", valid_s, 1);
    chk("sat2_count", count_s, 1);
    chk("sat2_ovf", ovf_s, 0);
    count_ready = 1'b1; step();
    count_ready = 1'b0;

    // Continuous mode
    cont = 1'b1; count_ready = 1'b1; hit = 1'b1;
    start = 1'b1; step();
    start = 1'b0;
    wait_valid(n);
    chk("cont_lat0", n, 8);
    chk("cont_count0", count_a, 8);
    chk("cont_ovf0", ovf_a, 0);
    for (int k = 1; k <= 2; k++) begin
      wait_valid(n);
      chk("cont_spacing", n, 9);
      chk("cont_count", count_a, 8);
      chk("cont_ovf", ovf_a, 0);
    end
    cont = 1'b0; step();
    chk("cont_exit_idle", busy_a, 0);
    hit = 1'b0;
    for (int i = 0; i < 4; i++) step();
    count_ready = 1'b0;

    // Reset mid-window
    start = 1'b1; hit = 1'b1; step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1; step();
    rst = 1'b0; hit = 1'b0;
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_count", count_a, 0);
    chk("rstmid_valid", valid_a, 0);
    start = 1'b1; step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      hit = (i == 2 || i == 5);
      step();
      if (i == 7) chk("fresh_valid7", valid_a, 0);
    end
    hit = 1'b0;
    chk("fresh_valid", valid_a, 1);
    chk("fresh_count", count_a, 2);
    count_ready = 1'b1; step();
    count_ready = 1'b0;

    // Ignored start during GATE and HOLD
    start = 1'b1; step();
    start = 1'b0;
    step(); step();
    start = 1'b1; step();                        // edge 3, mid-gate
    start = 1'b0;
    wait_valid(n);
    chk("ign_lat", n, 5);
    chk("ign_count", count_a, 0);
    start = 1'b1; step();
    start = 1'b0;
    chk("ign_hold_valid", valid_a, 1);
    chk("ign_hold_busy", busy_a, 1);
    count_ready = 1'b1; step();
    count_ready = 1'b0;
    chk("ign_idle", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
